fifo_prog_flags: RTL



---
 rtl/fifo_pkg.sv | 14 +
 rtl/fifo_flag_gen.sv | 23 ++
 rtl/fifo_prog_flags.sv | 115 +++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared types and width helpers for the programmable-flag FIFO family.
package fifo_pkg;

    typedef enum logic {
        RD_REG  = 1'b0,
        RD_FWFT = 1'b1
    } rd_mode_e;

    // Occupancy must represent 0..DEPTH inclusive, hence one bit above the pointer width.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_flag_gen.sv
// Decodes occupancy and run-time thresholds into full/empty/almost flags.
// Purely combinational: flags follow the registered count and threshold inputs directly.
module fifo_flag_gen
    import fifo_pkg::*;
#(
    parameter int  DEPTH = 16,
    localparam int CW    = cnt_width(DEPTH)
) (
    input  logic [CW-1:0] count_i,
    input  logic [CW-1:0] af_thresh_i,
    input  logic [CW-1:0] ae_thresh_i,
    output logic          full_o,
    output logic          empty_o,
    output logic          almost_full_o,
    output logic          almost_empty_o
);

    assign full_o         = (count_i == CW'(DEPTH));
    assign empty_o        = (count_i == '0);
    assign almost_full_o  = (count_i >= af_thresh_i);
    assign almost_empty_o = (count_i <= ae_thresh_i);

endmodule

// File: rtl/fifo_prog_flags.sv
// Single-clock FIFO with programmable almost flags, live count and sticky errors.
// Read is 1-cycle registered (FWFT=0) or zero-latency fall-through (FWFT=1); writes at full / reads at empty are dropped.
module fifo_prog_flags
    import fifo_pkg::*;
#(
    parameter int  DATA_WIDTH = 32,
    parameter int  DEPTH      = 16,
    parameter int  FWFT       = 0,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic [ADDR_WIDTH:0]   ae_thresh,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    input  logic                  err_clr,
    output logic                  overflow,
    output logic                  underflow
);

    localparam rd_mode_e RD_MODE = (FWFT != 0) ? RD_FWFT : RD_REG;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  wr_acc, rd_acc;

    // Acceptance uses pre-edge flags, so there is no pass-through at full or empty.
    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    assign wr_ptr_d = wr_acc ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
    assign rd_ptr_d = rd_acc ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
    assign count_d  = count_q + {{ADDR_WIDTH{1'b0}}, wr_acc} - {{ADDR_WIDTH{1'b0}}, rd_acc};

    // Set has priority over clear so a coincident error is never lost.
    assign ovf_d = (wr_en & full)  | (ovf_q & ~err_clr);
    assign udf_d = (rd_en & empty) | (udf_q & ~err_clr);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    generate
        if (RD_MODE == RD_FWFT) begin : g_fwft
            assign data_out   = mem_q[rd_ptr_q];
            assign data_valid = ~empty;
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] dout_q;
            logic                  dvld_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_q <= '0;
                    dvld_q <= 1'b0;
                end else begin
                    dvld_q <= rd_acc;
                    if (rd_acc) begin
                        dout_q <= mem_q[rd_ptr_q];
                    end
                end
            end

            assign data_out   = dout_q;
            assign data_valid = dvld_q;
        end
    endgenerate

    fifo_flag_gen #(
        .DEPTH (DEPTH)
    ) u_flag_gen (
        .count_i        (count_q),
        .af_thresh_i    (af_thresh),
        .ae_thresh_i    (ae_thresh),
        .full_o         (full),
        .empty_o        (empty),
        .almost_full_o  (almost_full),
        .almost_empty_o (almost_empty)
    );

    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = udf_q;

endmodule
